data_access_unit: RTL and testbench

Load/store unit between the execute stage and memory_access. It converts execute-stage load/store requests into SRAM-like data-bus transactions (req/addr_ok/data_ok), generates byte strobes and replicated store data, and aligns and extends load data. Results feed mem_read_data_in of memory_access. The pipeline is stalled while a transaction is outstanding.

---
 rtl/data_access_unit.sv | 164 ++++++++++++++++
 tb/tb_data_access_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_access_unit.sv
// Load/store unit: turns execute-stage memory ops into SRAM-like bus transactions
// (req/addr_ok/data_ok), builds store strobes/data and aligns/extends load data.
module data_access_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        exe_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_CANCEL = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        wr_q, wr_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;

    logic        is_half, is_word, misaligned, access, start;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Size 3 behaves as a word access everywhere.
    always_comb begin
        is_half    = (ls_size == 2'd1);
        is_word    = ls_size[1];
        misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        access     = exe_valid & (mem_read | mem_write) & (state_q == S_IDLE) & ~flush;
        start      = access & ~misaligned;
        addr_err   = access & misaligned;
    end

    always_comb begin
        if (is_word) begin
            st_strb = 4'b1111;
            st_data = store_data;
        end else if (is_half) begin
            st_strb = addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{store_data[15:0]}};
        end else begin
            st_strb = 4'b0001 << addr[1:0];
            st_data = {4{store_data[7:0]}};
        end
    end

    // Lane selection uses the offset latched at request time, not the live address.
    always_comb begin
        ld_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (size_q)
            2'd0:    ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = data_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wr_d         = wr_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    addr_d  = addr;
                    size_d  = ls_size;
                    wr_d    = mem_write;
                    uns_d   = ls_unsigned;
                    wdata_d = st_data;
                    wstrb_d = mem_write ? st_strb : 4'b0000;
                end
            end
            S_REQ: begin
                // Once accepted the response must still be drained, even if flushed.
                if (data_addr_ok) state_d = flush ? S_CANCEL : S_WAIT;
                else if (flush)   state_d = S_IDLE;
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = S_IDLE;
                    if (!flush && !wr_q) begin
                        load_data_d  = ld_ext;
                        load_valid_d = 1'b1;
                    end
                end else if (flush) begin
                    state_d = S_CANCEL;
                end
            end
            default: begin
                if (data_data_ok) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            wr_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wr_q         <= wr_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
        end
    end

    assign data_req   = (state_q == S_REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign stall      = start | (state_q == S_REQ) | ((state_q == S_WAIT) & ~data_data_ok)
                      | (state_q == S_CANCEL);

endmodule

// File: tb/tb_data_access_unit.sv
// Bench for data_access_unit: directed vector table, flush/reset sequences and
// randomized ops checked against an arithmetic reference model.
module tb_data_access_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        exe_valid, mem_read, mem_write, ls_unsigned, flush;
    logic [1:0]  ls_size;
    logic [31:0] addr, store_data;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        stall, load_valid, addr_err;
    logic [31:0] load_data;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] last_ld;

    always #5 clk = ~clk;

    data_access_unit dut (
        .clk(clk), .rstn(rstn), .exe_valid(exe_valid), .mem_read(mem_read),
        .mem_write(mem_write), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .addr(addr), .store_data(store_data), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
        .data_data_ok(data_data_ok), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .addr_err(addr_err)
    );

    typedef struct {
        string       nm;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a, sd, rd;
        int          aok, dok;
        logic        err;
        logic [3:0]  strb;
        logic [31:0] wdata, ld;
    } vec_t;

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, what, act, exp);
        end
    endtask

    // Reference model: byte count of the access, then plain arithmetic.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
        int n = nbytes(sz);
        if (n == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(sz);
        longint v;
        v = (longint'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
        if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return 32'(v);
    endfunction

    task automatic idle_inputs();
        exe_valid = 0; mem_read = 0; mem_write = 0; ls_size = 0; ls_unsigned = 0;
        addr = 0; store_data = 0; flush = 0;
    endtask

    task automatic run_op(input vec_t v);
        @(posedge clk); #1;
        exe_valid = 1; mem_write = v.wr; mem_read = !v.wr; ls_size = v.sz;
        ls_unsigned = v.uns; addr = v.a; store_data = v.sd;
        @(negedge clk);
        chk(v.nm, "addr_err", addr_err, v.err);
        if (v.err) begin
            chk(v.nm, "stall_err", stall, 0);
            @(posedge clk); #1; idle_inputs();
            @(negedge clk);
            chk(v.nm, "req_err", data_req, 0);
            chk(v.nm, "lv_err", load_valid, 0);
            return;
        end
        chk(v.nm, "stall_start", stall, 1);
        for (int k = 0; k <= v.aok; k++) begin
            @(posedge clk); #1;
            data_addr_ok = (k == v.aok);
            @(negedge clk);
            chk(v.nm, "req", data_req, 1);
            chk(v.nm, "addr", data_addr, v.a);
            chk(v.nm, "size", data_size, v.sz);
            chk(v.nm, "wr", data_wr, v.wr);
            chk(v.nm, "wstrb", data_wstrb, v.strb);
            if (v.wr) chk(v.nm, "wdata", data_wdata, v.wdata);
            chk(v.nm, "stall_req", stall, 1);
        end
        @(posedge clk); #1;
        data_addr_ok = 0;
        for (int k = 0; k < v.dok; k++) begin
            @(negedge clk);
            chk(v.nm, "req_wait", data_req, 0);
            chk(v.nm, "stall_wait", stall, 1);
            @(posedge clk); #1;
        end
        data_data_ok = 1; data_rdata = v.rd;
        @(negedge clk);
        chk(v.nm, "stall_dok", stall, 0);
        @(posedge clk); #1;
        data_data_ok = 0; data_rdata = $urandom; idle_inputs();
        if (!v.wr) last_ld = v.ld;
        @(negedge clk);
        chk(v.nm, "load_valid", load_valid, !v.wr);
        chk(v.nm, "load_data", load_data, last_ld);
        @(posedge clk); #1;
        @(negedge clk);
        chk(v.nm, "lv_clear", load_valid, 0);
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        tbl[0]  = '{"LB",    0, 2'd0, 0, 32'h1003, 32'h0,         32'h80FF_1234, 0, 0, 0, 4'b0000, 32'h0,         32'hFFFF_FF80};
        tbl[1]  = '{"LHU",   0, 2'd1, 1, 32'h2002, 32'h0,         32'hBEEF_0000, 3, 0, 0, 4'b0000, 32'h0,         32'h0000_BEEF};
        tbl[2]  = '{"SB",    1, 2'd0, 0, 32'h10,   32'h1234_56AB, 32'h0,         0, 1, 0, 4'b0001, 32'hABAB_ABAB, 32'h0};
        tbl[3]  = '{"SH",    1, 2'd1, 0, 32'h12,   32'h1234_56AB, 32'h0,         1, 0, 0, 4'b1100, 32'h56AB_56AB, 32'h0};
        tbl[4]  = '{"LWmis", 0, 2'd2, 0, 32'h101,  32'h0,         32'h0,         0, 0, 1, 4'b0000, 32'h0,         32'h0};
        tbl[5]  = '{"SHmis", 1, 2'd1, 0, 32'h3,    32'h0,         32'h0,         0, 0, 1, 4'b0000, 32'h0,         32'h0};
        tbl[6]  = '{"LW",    0, 2'd2, 0, 32'h2000, 32'h0,         32'hCAFE_F00D, 0, 2, 0, 4'b0000, 32'h0,         32'hCAFE_F00D};
        tbl[7]  = '{"LH",    0, 2'd1, 0, 32'h2,    32'h0,         32'h8001_0000, 1, 1, 0, 4'b0000, 32'h0,         32'hFFFF_8001};
        tbl[8]  = '{"SW",    1, 2'd2, 0, 32'h4,    32'hA5A5_1234, 32'h0,         0, 0, 0, 4'b1111, 32'hA5A5_1234, 32'h0};
        tbl[9]  = '{"LBU",   0, 2'd0, 1, 32'h1,    32'h0,         32'h0000_F200, 0, 0, 0, 4'b0000, 32'h0,         32'h0000_00F2};
        tbl[10] = '{"LW3",   0, 2'd3, 0, 32'h8,    32'h0,         32'h1122_3344, 0, 0, 0, 4'b0000, 32'h0,         32'h1122_3344};

        idle_inputs();
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        last_ld = 0;
        rstn = 0;
        #3;
        chk("reset", "req", data_req, 0);
        chk("reset", "stall", stall, 0);
        chk("reset", "load_data", load_data, 0);
        chk("reset", "wstrb", data_wstrb, 0);
        #10 rstn = 1;

        foreach (tbl[i]) run_op(tbl[i]);

        // Flush while waiting: response drained through CANCEL and discarded.
        @(posedge clk); #1;
        exe_valid = 1; mem_read = 1; ls_size = 2'd2; addr = 32'h40;
        @(negedge clk); chk("flw", "stall_start", stall, 1);
        @(posedge clk); #1; data_addr_ok = 1;
        @(negedge clk); chk("flw", "req", data_req, 1);
        @(posedge clk); #1; data_addr_ok = 0; flush = 1; exe_valid = 0; mem_read = 0;
        @(negedge clk); chk("flw", "stall_flush", stall, 1);
        @(posedge clk); #1; flush = 0;
        @(negedge clk); chk("flw", "stall_cancel", stall, 1); chk("flw", "req_cancel", data_req, 0);
        @(posedge clk); #1; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk); chk("flw", "stall_dok", stall, 1);
        @(posedge clk); #1; data_data_ok = 0;
        @(negedge clk);
        chk("flw", "load_valid", load_valid, 0);
        chk("flw", "load_data", load_data, last_ld);
        chk("flw", "stall_idle", stall, 0);

        // Flush in REQ before acceptance withdraws the request.
        @(posedge clk); #1;
        exe_valid = 1; mem_read = 1; ls_size = 2'd0; addr = 32'h7;
        @(posedge clk); #1; flush = 1; exe_valid = 0; mem_read = 0;
        @(negedge clk); chk("flr", "req", data_req, 1);
        @(posedge clk); #1; flush = 0;
        @(negedge clk); chk("flr", "req_gone", data_req, 0); chk("flr", "stall", stall, 0);

        // Flush together with data_ok in WAIT: result discarded.
        @(posedge clk); #1;
        exe_valid = 1; mem_read = 1; ls_size = 2'd2; addr = 32'h80;
        @(posedge clk); #1; data_addr_ok = 1;
        @(posedge clk); #1; data_addr_ok = 0; flush = 1; data_data_ok = 1; data_rdata = 32'h1357_9BDF;
        exe_valid = 0; mem_read = 0;
        @(posedge clk); #1; flush = 0; data_data_ok = 0;
        @(negedge clk);
        chk("fdo", "load_valid", load_valid, 0);
        chk("fdo", "load_data", load_data, last_ld);
        chk("fdo", "stall", stall, 0);

        // Asynchronous reset in WAIT.
        @(posedge clk); #1;
        exe_valid = 1; mem_write = 1; ls_size = 2'd0; addr = 32'h21; store_data = 32'h77;
        @(posedge clk); #1; data_addr_ok = 1;
        @(posedge clk); #1; data_addr_ok = 0;
        #2; idle_inputs(); rstn = 0;
        #1;
        chk("arst", "req", data_req, 0);
        chk("arst", "wr", data_wr, 0);
        chk("arst", "stall", stall, 0);
        chk("arst", "addr", data_addr, 0);
        chk("arst", "wstrb", data_wstrb, 0);
        chk("arst", "wdata", data_wdata, 0);
        chk("arst", "load_data", load_data, 0);
        last_ld = 0;
        @(negedge clk); rstn = 1;
        rv = '{"LWpost", 0, 2'd2, 0, 32'h3000, 32'h0, 32'h0BAD_F00D, 1, 1, 0, 4'b0000, 32'h0, 32'h0BAD_F00D};
        run_op(rv);

        for (int i = 0; i < 40; i++) begin
            rv.nm    = $sformatf("rnd%0d", i);
            rv.wr    = 1'($urandom_range(0, 1));
            rv.sz    = 2'($urandom_range(0, 3));
            rv.uns   = 1'($urandom_range(0, 1));
            rv.a     = $urandom;
            if ($urandom_range(0, 3) != 0) rv.a = rv.a & ~32'(nbytes(rv.sz) - 1);
            rv.sd    = $urandom;
            rv.rd    = $urandom;
            rv.aok   = $urandom_range(0, 2);
            rv.dok   = $urandom_range(0, 2);
            rv.err   = m_err(rv.sz, rv.a);
            rv.strb  = rv.wr ? m_strb(rv.sz, rv.a) : 4'b0000;
            rv.wdata = m_wdata(rv.sz, rv.sd);
            rv.ld    = m_load(rv.sz, rv.uns, rv.a, rv.rd);
            run_op(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
